// File: rtl/apb_gpio_pkg.sv
// Shared definitions for the APB GPIO block: register offsets and the
// APB handshake state type.
package apb_gpio_pkg;

    localparam logic [7:0] GPIO_MODE_OFS  = 8'h00;
    localparam logic [7:0] GPIO_ODR_OFS   = 8'h04;
    localparam logic [7:0] GPIO_IDR_OFS   = 8'h08;
    localparam logic [7:0] GPIO_OSET_OFS  = 8'h0C;
    localparam logic [7:0] GPIO_OCLR_OFS  = 8'h10;
    localparam logic [7:0] GPIO_IER_OFS   = 8'h14;
    localparam logic [7:0] GPIO_IEDGE_OFS = 8'h18;
    localparam logic [7:0] GPIO_ISR_OFS   = 8'h1C;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } apb_state_e;

    // Word index of a byte offset inside the 8-register window.
    function automatic logic [2:0] ofs_idx(input logic [7:0] ofs);
        return ofs[4:2];
    endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// Pad input synchroniser: two flops into IDR, a delayed copy of IDR, and the
// per-pin rise/fall events derived from the two.
module gpio_in_sync
    import apb_gpio_pkg::*;
#(
    parameter int unsigned NUM_IO = 8
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [NUM_IO-1:0] pad,
    output logic [NUM_IO-1:0] idr,
    output logic [NUM_IO-1:0] rise,
    output logic [NUM_IO-1:0] fall
);

    logic [NUM_IO-1:0] sync1_r;
    logic [NUM_IO-1:0] idr_r;
    logic [NUM_IO-1:0] prev_r;

    // Metastability chain followed by the one-cycle history register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sync1_r <= '0;
            idr_r   <= '0;
            prev_r  <= '0;
        end else begin
            sync1_r <= pad;
            idr_r   <= sync1_r;
            prev_r  <= idr_r;
        end
    end

    assign idr  = idr_r;
    assign rise = idr_r & ~prev_r;
    assign fall = ~idr_r & prev_r;

endmodule

// File: rtl/apb_gpio.sv
// APB GPIO slave: per-pin direction, output data with set/clear aliases,
// synchronised input read-back and edge-detect interrupts.
module apb_gpio
    import apb_gpio_pkg::*;
#(
    parameter int unsigned NUM_IO = 8,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic              PWRITE,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    input  logic [NUM_IO-1:0] gpio_i,
    output logic [NUM_IO-1:0] gpio_o,
    output logic [NUM_IO-1:0] gpio_oe,
    output logic              irq
);

    localparam logic [2:0] MODE_IDX  = ofs_idx(GPIO_MODE_OFS);
    localparam logic [2:0] ODR_IDX   = ofs_idx(GPIO_ODR_OFS);
    localparam logic [2:0] IDR_IDX   = ofs_idx(GPIO_IDR_OFS);
    localparam logic [2:0] OSET_IDX  = ofs_idx(GPIO_OSET_OFS);
    localparam logic [2:0] OCLR_IDX  = ofs_idx(GPIO_OCLR_OFS);
    localparam logic [2:0] IER_IDX   = ofs_idx(GPIO_IER_OFS);
    localparam logic [2:0] IEDGE_IDX = ofs_idx(GPIO_IEDGE_OFS);
    localparam logic [2:0] ISR_IDX   = ofs_idx(GPIO_ISR_OFS);

    apb_state_e        state_r, state_next_s;
    logic              pready_r;
    logic [31:0]       prdata_r;
    logic [NUM_IO-1:0] mode_r, odr_r, ier_r, iedge_r, isr_r, gpio_o_r;
    logic              irq_r;

    logic [NUM_IO-1:0] mode_next_s, odr_next_s, ier_next_s, iedge_next_s, isr_next_s;
    logic [NUM_IO-1:0] w1c_s, event_s, rdata_s, wdata_s;
    logic [NUM_IO-1:0] idr_s, rise_s, fall_s;
    logic [31:0]       word_s, prdata_ext_s;
    logic [2:0]        idx_s;
    logic              mapped_s, access_s, wr_s, rd_s;
    logic              unused_s;

    gpio_in_sync #(.NUM_IO(NUM_IO)) u_in_sync (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .pad    (gpio_i),
        .idr    (idr_s),
        .rise   (rise_s),
        .fall   (fall_s)
    );

    assign unused_s = ^{PADDR[1:0], PWDATA};
    assign wdata_s  = PWDATA[NUM_IO-1:0];
    assign access_s = (state_r == IDLE) && PSEL && PENABLE;
    assign wr_s     = access_s && PWRITE;
    assign rd_s     = access_s && !PWRITE;
    assign event_s  = (rise_s & ~iedge_r) | (fall_s & iedge_r);

    // Word decode; anything beyond the 8-register window is unmapped.
    always_comb begin
        word_s = 32'd0;
        word_s[ADDR_W-3:0] = PADDR[ADDR_W-1:2];
        idx_s    = word_s[2:0];
        mapped_s = (word_s[31:3] == 29'd0);
    end

    // APB handshake: a single wait state, then one cycle of PREADY.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (PSEL && PENABLE) begin
                    state_next_s = ACK;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACK:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Register write decode and ISR update; a new edge event beats a W1C.
    always_comb begin
        mode_next_s  = mode_r;
        odr_next_s   = odr_r;
        ier_next_s   = ier_r;
        iedge_next_s = iedge_r;
        w1c_s        = '0;
        if (wr_s && mapped_s) begin
            case (idx_s)
                MODE_IDX:  mode_next_s  = wdata_s;
                ODR_IDX:   odr_next_s   = wdata_s;
                OSET_IDX:  odr_next_s   = odr_r | wdata_s;
                OCLR_IDX:  odr_next_s   = odr_r & ~wdata_s;
                IER_IDX:   ier_next_s   = wdata_s;
                IEDGE_IDX: iedge_next_s = wdata_s;
                ISR_IDX:   w1c_s        = wdata_s;
                default:   w1c_s        = '0;
            endcase
        end else begin
            w1c_s = '0;
        end
        isr_next_s = (isr_r & ~w1c_s) | event_s;
    end

    // Read data mux; write-only and unmapped offsets return zero.
    always_comb begin
        rdata_s = '0;
        if (mapped_s) begin
            case (idx_s)
                MODE_IDX:  rdata_s = mode_r;
                ODR_IDX:   rdata_s = odr_r;
                IDR_IDX:   rdata_s = idr_s;
                IER_IDX:   rdata_s = ier_r;
                IEDGE_IDX: rdata_s = iedge_r;
                ISR_IDX:   rdata_s = isr_r;
                default:   rdata_s = '0;
            endcase
        end else begin
            rdata_s = '0;
        end
        prdata_ext_s = 32'd0;
        prdata_ext_s[NUM_IO-1:0] = rdata_s;
    end

    // State, register file and registered outputs.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_r  <= IDLE;
            pready_r <= 1'b0;
            prdata_r <= 32'd0;
            mode_r   <= '0;
            odr_r    <= '0;
            ier_r    <= '0;
            iedge_r  <= '0;
            isr_r    <= '0;
            irq_r    <= 1'b0;
            gpio_o_r <= '0;
        end else begin
            state_r  <= state_next_s;
            pready_r <= access_s;
            if (rd_s) begin
                prdata_r <= prdata_ext_s;
            end
            mode_r   <= mode_next_s;
            odr_r    <= odr_next_s;
            ier_r    <= ier_next_s;
            iedge_r  <= iedge_next_s;
            isr_r    <= isr_next_s;
            irq_r    <= |(isr_r & ier_r);
            gpio_o_r <= odr_next_s & mode_next_s;
        end
    end

    assign PRDATA  = prdata_r;
    assign PREADY  = pready_r;
    assign gpio_oe = mode_r;
    assign gpio_o  = gpio_o_r;
    assign irq     = irq_r;

endmodule

// File: tb/tb_apb_gpio.sv
// Bench for apb_gpio: an 8-pin and a 4-pin instance share one APB bus and
// pad vector and are checked every cycle against a behavioural model.
module tb_apb_gpio;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic [5:0]  PADDR = 6'd0;
    logic        PWRITE = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic [31:0] PWDATA = 32'd0;
    logic [7:0]  gpio_i = 8'd0;

    logic [31:0] prdata8, prdata4;
    logic        pready8, pready4, irq8, irq4;
    logic [7:0]  gpio_o8, gpio_oe8;
    logic [3:0]  gpio_o4, gpio_oe4;

    apb_gpio #(.NUM_IO(8), .ADDR_W(5)) dut8 (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR[4:0]), .PWRITE(PWRITE),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWDATA(PWDATA), .PRDATA(prdata8),
        .PREADY(pready8), .gpio_i(gpio_i), .gpio_o(gpio_o8), .gpio_oe(gpio_oe8),
        .irq(irq8)
    );

    apb_gpio #(.NUM_IO(4), .ADDR_W(6)) dut4 (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWRITE(PWRITE),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWDATA(PWDATA), .PRDATA(prdata4),
        .PREADY(pready4), .gpio_i(gpio_i[3:0]), .gpio_o(gpio_o4), .gpio_oe(gpio_oe4),
        .irq(irq4)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: index 0 is the 8-pin/5-bit-address part, 1 the 4-pin/6-bit one.
    logic [31:0] m_mode[2], m_odr[2], m_ier[2], m_iedge[2], m_isr[2], m_prdata[2];
    logic        m_irq[2], m_pready[2];
    logic [31:0] pads[3];
    logic [31:0] now_t, prv_t, ev_t, w1c_t, mk_t;
    int          idx_t;
    logic        commit_f = 1'b0;
    logic        run_cmp = 1'b0;

    function automatic logic [31:0] msk(input int k);
        return (k == 0) ? 32'h0000_00FF : 32'h0000_000F;
    endfunction

    function automatic logic [31:0] model_read(input int k, input int idx, input logic [31:0] idr);
        case (idx)
            0:       return m_mode[k];
            1:       return m_odr[k];
            2:       return idr & msk(k);
            5:       return m_ier[k];
            6:       return m_iedge[k];
            7:       return m_isr[k];
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int k = 0; k < 2; k++) begin
                m_mode[k] = 32'd0; m_odr[k] = 32'd0; m_ier[k] = 32'd0;
                m_iedge[k] = 32'd0; m_isr[k] = 32'd0; m_prdata[k] = 32'd0;
                m_irq[k] = 1'b0; m_pready[k] = 1'b0;
            end
            for (int j = 0; j < 3; j++) pads[j] = 32'd0;
        end else begin
            // pads[1] is the pad as seen two edges ago (current IDR), pads[2] one before that.
            now_t = pads[1];
            prv_t = pads[2];
            for (int k = 0; k < 2; k++) begin
                mk_t = msk(k);
                ev_t = 32'd0;
                for (int i = 0; i < 8; i++) begin
                    if (mk_t[i] && now_t[i] != prv_t[i]) begin
                        if (m_iedge[k][i] == now_t[i]) ev_t[i] = 1'b0;
                        else ev_t[i] = 1'b1;
                    end
                end
                m_irq[k] = ((m_isr[k] & m_ier[k]) != 32'd0);
                m_pready[k] = commit_f;
                w1c_t = 32'd0;
                if (commit_f) begin
                    idx_t = (k == 0) ? int'(PADDR[4:0]) / 4 : int'(PADDR) / 4;
                    if (!PWRITE) begin
                        m_prdata[k] = model_read(k, idx_t, now_t);
                    end else begin
                        case (idx_t)
                            0: m_mode[k] = PWDATA & mk_t;
                            1: m_odr[k] = PWDATA & mk_t;
                            3: m_odr[k] = m_odr[k] | (PWDATA & mk_t);
                            4: m_odr[k] = m_odr[k] & ~PWDATA;
                            5: m_ier[k] = PWDATA & mk_t;
                            6: m_iedge[k] = PWDATA & mk_t;
                            7: w1c_t = PWDATA & mk_t;
                            default: w1c_t = 32'd0;
                        endcase
                    end
                end
                m_isr[k] = (m_isr[k] & ~w1c_t) | ev_t;
            end
            pads[2] = pads[1];
            pads[1] = pads[0];
            pads[0] = {24'd0, gpio_i};
        end
    end

    always @(negedge PCLK) begin
        if (run_cmp) begin
            check("pready8", {31'd0, pready8}, {31'd0, m_pready[0]});
            check("pready4", {31'd0, pready4}, {31'd0, m_pready[1]});
            check("prdata8", prdata8, m_prdata[0]);
            check("prdata4", prdata4, m_prdata[1]);
            check("gpio_oe8", {24'd0, gpio_oe8}, m_mode[0]);
            check("gpio_oe4", {28'd0, gpio_oe4}, m_mode[1]);
            check("gpio_o8", {24'd0, gpio_o8}, m_odr[0] & m_mode[0]);
            check("gpio_o4", {28'd0, gpio_o4}, m_odr[1] & m_mode[1]);
            check("irq8", {31'd0, irq8}, {31'd0, m_irq[0]});
            check("irq4", {31'd0, irq4}, {31'd0, m_irq[1]});
        end
    end

    // One APB transfer; called and returning 1 time unit after a rising edge.
    task automatic xfer(input logic wr, input logic [5:0] a, input logic [31:0] d,
                        output logic [31:0] r8, output logic [31:0] r4);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d; commit_f = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1; commit_f = 1'b1;
        @(posedge PCLK); #1;
        commit_f = 1'b0;
        check("pready_ack", {31'd0, pready8}, 32'd1);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        check("pready_end", {31'd0, pready8}, 32'd0);
        r8 = prdata8;
        r4 = prdata4;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r8, r4;
        PRESET = 1'b1;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;
        run_cmp = 1'b1;

        // Reset state: every offset reads 0, pins are inputs.
        for (int a = 0; a < 32; a += 4) begin
            xfer(1'b0, 6'(a), 32'd0, r8, r4);
            check("rst_rd8", r8, 32'd0);
            check("rst_rd4", r4, 32'd0);
        end
        check("rst_oe", {24'd0, gpio_oe8}, 32'd0);
        check("rst_irq", {31'd0, irq8}, 32'd0);

        // Direction, output data, set/clear aliases.
        xfer(1'b1, 6'h00, 32'h0F, r8, r4);
        xfer(1'b1, 6'h04, 32'hAA, r8, r4);
        check("oe_0f", {24'd0, gpio_oe8}, 32'h0F);
        check("o_0a", {24'd0, gpio_o8}, 32'h0A);
        xfer(1'b1, 6'h0C, 32'h05, r8, r4);
        xfer(1'b0, 6'h04, 32'd0, r8, r4);
        check("odr_oset", r8, 32'hAF);
        xfer(1'b0, 6'h0C, 32'd0, r8, r4);
        check("oset_rd0", r8, 32'd0);
        xfer(1'b1, 6'h10, 32'h0A, r8, r4);
        xfer(1'b0, 6'h04, 32'd0, r8, r4);
        check("odr_oclr", r8, 32'hA5);

        // Input path latency.
        xfer(1'b1, 6'h00, 32'h00, r8, r4);
        gpio_i = 8'h3C;
        xfer(1'b0, 6'h08, 32'd0, r8, r4);
        check("idr_early", r8, 32'h00);
        xfer(1'b0, 6'h08, 32'd0, r8, r4);
        check("idr_late", r8, 32'h3C);
        xfer(1'b1, 6'h1C, 32'hFF, r8, r4);
        xfer(1'b0, 6'h1C, 32'd0, r8, r4);
        check("isr_cleared", r8, 32'h00);

        // Rising-edge interrupt on pin 0 and W1C.
        xfer(1'b1, 6'h14, 32'h01, r8, r4);
        xfer(1'b1, 6'h18, 32'h00, r8, r4);
        gpio_i = 8'h3D;
        repeat (3) @(posedge PCLK);
        #1 check("irq_t3", {31'd0, irq8}, 32'd0);
        @(posedge PCLK);
        #1 check("irq_t4", {31'd0, irq8}, 32'd1);
        xfer(1'b0, 6'h1C, 32'd0, r8, r4);
        check("isr_rise", r8, 32'h01);
        gpio_i = 8'h3C;
        repeat (5) @(posedge PCLK);
        #1;
        xfer(1'b0, 6'h1C, 32'd0, r8, r4);
        check("isr_nofall", r8, 32'h01);
        xfer(1'b1, 6'h1C, 32'h01, r8, r4);
        check("irq_drop", {31'd0, irq8}, 32'd0);
        xfer(1'b0, 6'h1C, 32'd0, r8, r4);
        check("isr_w1c", r8, 32'h00);

        // Falling-edge on pin 1 with IER=0, then set-beats-clear.
        xfer(1'b1, 6'h18, 32'h02, r8, r4);
        xfer(1'b1, 6'h14, 32'h00, r8, r4);
        gpio_i = 8'h3E;
        repeat (5) @(posedge PCLK);
        #1 gpio_i = 8'h3C;
        repeat (5) @(posedge PCLK);
        #1;
        xfer(1'b0, 6'h1C, 32'd0, r8, r4);
        check("isr_fall", r8, 32'h02);
        check("irq_masked", {31'd0, irq8}, 32'd0);
        gpio_i = 8'h3E;
        repeat (5) @(posedge PCLK);
        #1 gpio_i = 8'h3C;
        @(posedge PCLK);
        #1;
        xfer(1'b1, 6'h1C, 32'h02, r8, r4);
        xfer(1'b0, 6'h1C, 32'd0, r8, r4);
        check("isr_set_wins", r8, 32'h02);

        // Width masking, ISR offset and unmapped window on the 4-pin part.
        xfer(1'b1, 6'h04, 32'hFFFF_FFFF, r8, r4);
        xfer(1'b1, 6'h00, 32'hFFFF_FFFF, r8, r4);
        xfer(1'b0, 6'h04, 32'd0, r8, r4);
        check("odr_w8", r8, 32'hFF);
        check("odr_w4", r4, 32'h0F);
        xfer(1'b0, 6'h00, 32'd0, r8, r4);
        check("mode_w4", r4, 32'h0F);
        xfer(1'b0, 6'h1C, 32'd0, r8, r4);
        check("isr_rd4", r4, 32'h02);
        xfer(1'b0, 6'h20, 32'd0, r8, r4);
        check("unmapped_rd4", r4, 32'h00);
        check("alias_rd8", r8, 32'hFF);
        xfer(1'b1, 6'h20, 32'h00, r8, r4);
        xfer(1'b0, 6'h00, 32'd0, r8, r4);
        check("alias_wr8", r8, 32'h00);
        check("unmapped_wr4", r4, 32'h0F);

        // Reset asserted while PREADY is high.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 6'h14; PWDATA = 32'h03;
        @(posedge PCLK); #1;
        PENABLE = 1'b1; commit_f = 1'b1;
        @(posedge PCLK); #1;
        commit_f = 1'b0;
        check("pready_pre_rst", {31'd0, pready8}, 32'd1);
        PRESET = 1'b1;
        #1;
        check("pready_rst8", {31'd0, pready8}, 32'd0);
        check("pready_rst4", {31'd0, pready4}, 32'd0);
        check("oe_rst4", {28'd0, gpio_oe4}, 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(posedge PCLK);
        #1;
        xfer(1'b0, 6'h14, 32'd0, r8, r4);
        check("ier_rst8", r8, 32'd0);
        check("ier_rst4", r4, 32'd0);
        xfer(1'b0, 6'h04, 32'd0, r8, r4);
        check("odr_rst8", r8, 32'd0);
        check("odr_rst4", r4, 32'd0);

        repeat (2) @(posedge PCLK);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_gpio.md
Name: apb_gpio

Overview:
- Parametrised APB GPIO slave; successor to the fixed 4-bit output-only GPO.
- Per-pin direction, output data with atomic set/clear, 2-flop synchronised input read-back, and per-pin edge-detect interrupts.
- Pins are exposed as separate out/oe/in vectors; tristate buffers live at the chip top.
- Sits on the APB bus behind the RISC-V core's APB master, alongside the other APB peripherals.

Parameters:
- NUM_IO, 8, number of GPIO pins (1..32).
- ADDR_W, 5, PADDR width; byte offsets, word-aligned.

Ports:
- PCLK  in  1  APB clock.
- PRESET  in  1  reset.
- PADDR  in  ADDR_W  byte address.
- PWRITE  in  1  1 = write.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer complete.
- gpio_i  in  NUM_IO  asynchronous pad inputs.
- gpio_o  out  NUM_IO  pad output values.
- gpio_oe  out  NUM_IO  pad output enables (1 = drive).
- irq  out  1  level interrupt.

Behaviour:
- Clock and reset: reset PRESET, asynchronous, active-high; clock PCLK. All state is on PCLK rising edge.
- Reset values: every register 0, PRDATA 0, PREADY 0, irq 0, gpio_o 0, gpio_oe 0. All pins come out of reset as inputs.
- Register map (offset, access, meaning):
  - 0x00 MODE, RW, 1 = output.
  - 0x04 ODR, RW, output data.
  - 0x08 IDR, RO, synchronised inputs.
  - 0x0C OSET, WO, ODR |= wdata; reads 0.
  - 0x10 OCLR, WO, ODR &= ~wdata; reads 0.
  - 0x14 IER, RW, interrupt enable.
  - 0x18 IEDGE, RW, 0 = rising, 1 = falling.
  - 0x1C ISR, R/W1C, edge status.
- Data width: only bits [NUM_IO-1:0] are stored. Upper PWDATA bits are ignored; upper PRDATA bits read 0.
- Decode: PADDR[ADDR_W-1:2]. PADDR[1:0] is ignored. Unmapped offsets (>= 0x20 when ADDR_W > 5) read 0; writes to them are ignored.
- APB handshake, two-state FSM (IDLE, ACK):
  - IDLE: when PSEL & PENABLE, go to ACK at the next edge. At that edge PREADY <= 1, the write is committed, or PRDATA is loaded for a read.
  - ACK: at the next edge, PREADY <= 0 and return to IDLE.
  - Every transfer therefore has exactly one wait state. PREADY is never high in two consecutive cycles.
  - PSEL without PENABLE has no effect.
  - PRDATA holds its last value between reads.
- Outputs: gpio_oe = MODE; gpio_o = ODR & MODE (input pins drive 0).
- Input path:
  - gpio_i goes through a 2-flop synchroniser into IDR, then a 1-cycle delayed copy (prev).
  - Rising event = IDR & ~prev; falling event = ~IDR & prev.
  - Total latency from a pad change to an IDR change: 2 PCLK edges. ISR sets 1 edge later.
  - IDR reflects the pad regardless of MODE.
- Interrupt status:
  - ISR[i] sets on the selected edge for pin i, regardless of IER.
  - Writing 1 to ISR clears the bit; writing 0 has no effect.
  - If a set event and a W1C land in the same cycle, set wins.
- irq: registered |(ISR & IER); asserts 1 cycle after the ISR bit is set.
- Changing IEDGE: takes effect for events after the write; it does not retroactively set ISR.
- Reset mid-transfer: FSM returns to IDLE, PREADY drops immediately, any pending write is lost.

Decomposition:
- apb_gpio_pkg:
  - Register offset localparams (GPIO_MODE_OFS ... GPIO_ISR_OFS).
  - FSM enum apb_state_e {IDLE, ACK}.
- Sub-module gpio_in_sync: per-vector 2-flop synchroniser, prev register and rise/fall event outputs. Parameterised by NUM_IO; clocked by PCLK, reset by PRESET.
- apb_gpio contains the APB FSM, the register file, the ISR/irq logic and the output assignments.

Test Plan:
1. Reset, then read all 8 offsets -> every PRDATA = 0; gpio_oe = 0, gpio_o = 0, irq = 0; PREADY high exactly one cycle per read, with one wait state.
2. Write MODE = 0x0F, ODR = 0xAA -> gpio_oe = 0x0F, gpio_o = 0x0A. Write OSET = 0x05 -> ODR reads 0xAF. Write OCLR = 0x0A -> ODR reads 0xA5.
3. MODE = 0; drive gpio_i = 0x3C at cycle t -> IDR reads 0x3C when sampled from t+2; a read of IDR issued before t+2 returns 0x00.
4. IER = 0x01, IEDGE = 0x00; toggle gpio_i[0] 0->1 -> ISR = 0x01 at t+3, irq = 1 at t+4. Toggle 1->0 -> ISR unchanged. Write ISR = 0x01 -> ISR = 0, irq drops next cycle.
5. IEDGE = 0x02, IER = 0; falling edge on gpio_i[1] -> ISR = 0x02, irq stays 0. A W1C ISR = 0x02 in the same cycle as a new falling edge -> ISR stays 0x02.
6. NUM_IO = 4 instance: write 0xFFFFFFFF to ODR/MODE -> reads 0x0000000F. Access offset 0x1C works; assert PRESET during ACK -> PREADY = 0 immediately, all registers = 0.
